// File: rtl/fetch_stage_pkg.sv
// Shared constants and encodings for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] PC_INC_DEF    = 16'd2;

    // Major opcode (instr[15:11]) that decode recognises as HALT; NOP uses 5'b00001.
    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_BUF   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE,
        IFID_FLUSH
    } ifid_op_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/done handshake between the fetch stage and the memory.
interface fetch_stage_if;
    logic        imemRd;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemDone;

    modport master (output imemRd, output imemAddr, input imemData, input imemDone);
    modport slave  (input imemRd, input imemAddr, output imemData, output imemDone);
endinterface

// File: rtl/fetch_stage_dff.sv
// Enable flop cell with asynchronous active-low reset to a parameterised value.
module fetch_stage_dff #(
    parameter int          WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register {instr, PC, valid} with load / hold / bubble / flush control.
module fetch_stage_ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  ifid_op_t    op,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        valid
);

    logic [15:0] instr_next;
    logic [15:0] pc_next;
    logic        valid_next;
    logic        en;

    always_comb begin
        en         = 1'b1;
        instr_next = instr;
        pc_next    = pc;
        valid_next = valid;
        case (op)
            IFID_LOAD: begin
                instr_next = load_instr;
                pc_next    = load_pc;
                valid_next = 1'b1;
            end
            // A bubble keeps the last PC so decode still sees a sensible PC+2.
            IFID_BUBBLE: begin
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
            end
            IFID_FLUSH: begin
                instr_next = NOP_INSTR;
                pc_next    = 16'h0000;
                valid_next = 1'b0;
            end
            default: en = 1'b0;
        endcase
    end

    fetch_stage_dff #(.WIDTH(16), .RESET_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .rst(rst), .en(en), .d(instr_next), .q(instr)
    );

    fetch_stage_dff #(.WIDTH(16), .RESET_VAL(16'h0000)) u_pc (
        .clk(clk), .rst(rst), .en(en), .d(pc_next), .q(pc)
    );

    fetch_stage_dff #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid (
        .clk(clk), .rst(rst), .en(en), .d(valid_next), .q(valid)
    );

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake FSM and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [15:0] PC_INC    = PC_INC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          memStall,
    input  logic          redirect,
    input  logic [15:0]   redirectPC,
    input  logic          haltDecoded,
    fetch_stage_if.master imem,
    output logic [15:0]   instrOut,
    output logic [15:0]   PCOut,
    output logic          validOut,
    output logic          fetchBusy
);

    logic [1:0]  state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] req_addr_reg, req_addr_next;
    logic [15:0] buf_reg, buf_next;
    logic        drain_halt_reg, drain_halt_next;

    ifid_op_t    ifid_op;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;

    logic        done;
    logic        hold;
    logic [15:0] pc_inc;

    assign done   = imem.imemDone;
    assign hold   = stall | memStall;
    assign pc_inc = pc_reg + PC_INC;

    // The request is masked while reset is asserted so memory never sees a stray read.
    assign imem.imemRd   = rst & ((state_reg == ST_FETCH) | (state_reg == ST_DRAIN));
    assign imem.imemAddr = (state_reg == ST_DRAIN) ? req_addr_reg : pc_reg;
    assign fetchBusy     = (state_reg == ST_DRAIN) | ((state_reg == ST_FETCH) & !done);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_addr_next   = req_addr_reg;
        buf_next        = buf_reg;
        drain_halt_next = drain_halt_reg;
        ifid_op         = IFID_HOLD;
        ifid_instr      = imem.imemData;
        ifid_pc         = pc_inc;

        if (state_reg == ST_FETCH) begin
            req_addr_next = pc_reg;
        end

        if (memStall) begin
            // Whole pipe frozen, but an in-flight read still lands somewhere.
            case (state_reg)
                ST_FETCH: if (done) begin
                    buf_next   = imem.imemData;
                    pc_next    = pc_inc;
                    state_next = ST_BUF;
                end
                ST_DRAIN: if (done) begin
                    state_next = drain_halt_reg ? ST_HALT : ST_FETCH;
                end
                default: ;
            endcase
        end else if (redirect) begin
            pc_next = redirectPC;
            ifid_op = IFID_FLUSH;
            if (((state_reg == ST_FETCH) || (state_reg == ST_DRAIN)) && !done) begin
                state_next      = ST_DRAIN;
                drain_halt_next = 1'b0;
            end else begin
                state_next = ST_FETCH;
            end
        end else if (haltDecoded && (state_reg == ST_FETCH)) begin
            ifid_op = IFID_BUBBLE;
            if (done) begin
                state_next = ST_HALT;
            end else begin
                state_next      = ST_DRAIN;
                drain_halt_next = 1'b1;
            end
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (done) begin
                        pc_next = pc_inc;
                        if (hold) begin
                            buf_next   = imem.imemData;
                            state_next = ST_BUF;
                        end else begin
                            ifid_op = IFID_LOAD;
                        end
                    end else if (!hold) begin
                        ifid_op = IFID_BUBBLE;
                    end
                end
                ST_BUF: if (!hold) begin
                    ifid_op    = IFID_LOAD;
                    ifid_instr = buf_reg;
                    ifid_pc    = pc_reg;
                    state_next = ST_FETCH;
                end
                ST_DRAIN: begin
                    if (done) begin
                        state_next = drain_halt_reg ? ST_HALT : ST_FETCH;
                    end
                    if (!hold) begin
                        ifid_op = IFID_BUBBLE;
                    end
                end
                default: if (!hold) begin
                    ifid_op = IFID_BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            buf_reg        <= NOP_INSTR;
            drain_halt_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_addr_reg   <= req_addr_next;
            buf_reg        <= buf_next;
            drain_halt_reg <= drain_halt_next;
        end
    end

    fetch_stage_ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .op        (ifid_op),
        .load_instr(ifid_instr),
        .load_pc   (ifid_pc),
        .instr     (instrOut),
        .pc        (PCOut),
        .valid     (validOut)
    );

endmodule
